// File: rtl/uart_pkg.sv
// Shared UART constants and divisor types.
// Reset divisors plus the 100 MHz / 38400-baud divisor pair.
package uart_pkg;

  localparam int BRG_NB_COUNT = 8;
  localparam int BRG_NB_FRAC = 8;
  localparam int BRG_OVERSAMPLE = 16;

  localparam int BRG_DIV_INT_RST = 163;
  localparam int BRG_DIV_FRAC_RST = 0;

  localparam int BRG_DIV_INT_38400 = 162;
  localparam int BRG_DIV_FRAC_38400 = 195;

  typedef struct packed {
    logic [BRG_NB_COUNT-1:0] div_int;
    logic [BRG_NB_FRAC-1:0]  div_frac;
  } brg_div_t;

endpackage

// File: rtl/brg_frac_accum.sv
// Fractional-N phase accumulator: next acc, carry, next period.
// Ports: acc/div in; next acc, carried period, sync base period out.
module brg_frac_accum
  import uart_pkg::*;
#(
  parameter int NB_COUNT = BRG_NB_COUNT,
  parameter int NB_FRAC  = BRG_NB_FRAC
) (
  input  logic [NB_FRAC-1:0]  i_acc,
  input  logic [NB_COUNT-1:0] i_div_int,
  input  logic [NB_FRAC-1:0]  i_div_frac,
  output logic [NB_FRAC-1:0]  o_acc,
  output logic [NB_COUNT:0]   o_period,
  output logic [NB_COUNT:0]   o_base
);

  logic [NB_FRAC:0]    sum;
  logic [NB_COUNT-1:0] div_eff;

  always_comb begin
    sum = {1'b0, i_acc} + {1'b0, i_div_frac};
    // A zero divisor would never wrap; run it as 1.
    div_eff = (i_div_int == '0) ? NB_COUNT'(1) : i_div_int;
    o_acc = sum[NB_FRAC-1:0];
    o_base = {1'b0, div_eff};
    o_period = o_base + {{NB_COUNT{1'b0}}, sum[NB_FRAC]};
  end

endmodule

// File: rtl/baudrate_generator_frac.sv
// Fractional baud generator: oversample tick, mid/bit strobes, shadowed divisor.
// Ports: clock/reset, enable, sync, load+divisor in; tick, mid, bit, pending, br_clock out. Macro: BRG_SQUARE_OUT_EN.
module baudrate_generator_frac
  import uart_pkg::*;
#(
  parameter int NB_COUNT         = BRG_NB_COUNT,
  parameter int NB_FRAC          = BRG_NB_FRAC,
  parameter int OVERSAMPLE       = BRG_OVERSAMPLE,
  parameter int DEFAULT_DIV_INT  = BRG_DIV_INT_RST,
  parameter int DEFAULT_DIV_FRAC = BRG_DIV_FRAC_RST
) (
  input  logic                i_clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_sync,
  input  logic                i_load,
  input  logic [NB_COUNT-1:0] i_div_int,
  input  logic [NB_FRAC-1:0]  i_div_frac,
  output logic                o_tick,
  output logic                o_mid_tick,
  output logic                o_bit_tick,
  output logic                o_pending,
  output logic                o_br_clock
);

  localparam int NB_SUB = $clog2(OVERSAMPLE);
  localparam int NB_PER = NB_COUNT + 1;

  localparam logic [NB_SUB-1:0] SUB_LAST = NB_SUB'(OVERSAMPLE - 1);
  localparam logic [NB_SUB-1:0] SUB_PRE_MID = NB_SUB'(OVERSAMPLE / 2 - 1);

  localparam logic [NB_COUNT-1:0] DIV_INT_RST = NB_COUNT'(DEFAULT_DIV_INT);
  localparam logic [NB_FRAC-1:0] DIV_FRAC_RST = NB_FRAC'(DEFAULT_DIV_FRAC);
  localparam logic [NB_PER-1:0] PERIOD_RST =
    (DEFAULT_DIV_INT == 0) ? NB_PER'(1) : {1'b0, DIV_INT_RST};

  logic [NB_COUNT-1:0] cnt_q, cnt_d;
  logic [NB_FRAC-1:0]  acc_q, acc_d;
  logic [NB_SUB-1:0]   sub_q, sub_d;
  logic [NB_PER-1:0]   period_q, period_d;
  logic [NB_COUNT-1:0] act_int_q, act_int_d;
  logic [NB_FRAC-1:0]  act_frac_q, act_frac_d;
  logic [NB_COUNT-1:0] shd_int_q, shd_int_d;
  logic [NB_FRAC-1:0]  shd_frac_q, shd_frac_d;
  logic                pend_q, pend_d;
  logic                tick_q, tick_d;
  logic                mid_q, mid_d;
  logic                bit_q, bit_d;

  logic                wrap;
  logic                apply;
  logic [NB_COUNT-1:0] use_int;
  logic [NB_FRAC-1:0]  use_frac;
  logic [NB_FRAC-1:0]  acc_nxt;
  logic [NB_PER-1:0]   period_nxt;
  logic [NB_PER-1:0]   period_base;

  assign wrap = ({1'b0, cnt_q} == (period_q - NB_PER'(1)));

  // Shadow lands on a wrap, a sync, or whenever counting is frozen.
  assign apply = pend_q & (i_sync | ~i_enable | wrap);

  // The period that starts at this edge already uses the new divisor.
  assign use_int = apply ? shd_int_q : act_int_q;
  assign use_frac = apply ? shd_frac_q : act_frac_q;

  brg_frac_accum #(
    .NB_COUNT(NB_COUNT),
    .NB_FRAC (NB_FRAC)
  ) u_accum (
    .i_acc     (acc_q),
    .i_div_int (use_int),
    .i_div_frac(use_frac),
    .o_acc     (acc_nxt),
    .o_period  (period_nxt),
    .o_base    (period_base)
  );

  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    sub_d = sub_q;
    period_d = period_q;
    act_int_d = use_int;
    act_frac_d = use_frac;
    shd_int_d = shd_int_q;
    shd_frac_d = shd_frac_q;
    pend_d = pend_q;
    tick_d = 1'b0;
    mid_d = 1'b0;
    bit_d = 1'b0;

    // A load on the apply edge re-arms pending with the new value.
    if (i_load) begin
      shd_int_d = i_div_int;
      shd_frac_d = i_div_frac;
      pend_d = 1'b1;
    end else if (apply) begin
      pend_d = 1'b0;
    end

    unique case (1'b1)
      i_sync: begin
        cnt_d = '0;
        acc_d = '0;
        sub_d = '0;
        period_d = period_base;
      end
      (!i_sync && !i_enable): begin
      end
      (!i_sync && i_enable && wrap): begin
        cnt_d = '0;
        acc_d = acc_nxt;
        period_d = period_nxt;
        tick_d = 1'b1;
        bit_d = (sub_q == SUB_LAST);
        mid_d = (sub_q == SUB_PRE_MID);
        sub_d = (sub_q == SUB_LAST) ? '0 : sub_q + NB_SUB'(1);
      end
      default: begin
        cnt_d = cnt_q + NB_COUNT'(1);
      end
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      cnt_q <= '0;
      acc_q <= '0;
      sub_q <= '0;
      period_q <= PERIOD_RST;
      act_int_q <= DIV_INT_RST;
      act_frac_q <= DIV_FRAC_RST;
      shd_int_q <= DIV_INT_RST;
      shd_frac_q <= DIV_FRAC_RST;
      pend_q <= 1'b0;
      tick_q <= 1'b0;
      mid_q <= 1'b0;
      bit_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
      sub_q <= sub_d;
      period_q <= period_d;
      act_int_q <= act_int_d;
      act_frac_q <= act_frac_d;
      shd_int_q <= shd_int_d;
      shd_frac_q <= shd_frac_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      mid_q <= mid_d;
      bit_q <= bit_d;
    end
  end

  assign o_tick = tick_q;
  assign o_mid_tick = mid_q;
  assign o_bit_tick = bit_q;
  assign o_pending = pend_q;

`ifdef BRG_SQUARE_OUT_EN
  logic br_q, br_d;

  always_comb begin
    br_d = br_q;
    if (i_sync) br_d = 1'b0;
    else if (bit_d) br_d = 1'b1;
    else if (mid_d) br_d = 1'b0;
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) br_q <= 1'b0;
    else br_q <= br_d;
  end

  assign o_br_clock = br_q;
`else
  assign o_br_clock = 1'b0;
`endif

endmodule

// File: doc/baudrate_generator_frac.md
Name: baudrate_generator_frac

Overview:
Parametrised successor baud-rate generator for the UART.
- Produces an oversampling tick from a runtime-programmable divisor with an integer and a fractional part (fractional-N accumulator).
- Derives bit-rate and mid-bit strobes from the oversampling tick.
- Supports phase resync for RX start-bit alignment.
- Feeds the UART rx/tx FSMs.

Parameters:
NB_COUNT, 8, width of the integer divisor and the period counter
NB_FRAC, 8, width of the fractional divisor and the phase accumulator
OVERSAMPLE, 16, o_tick pulses per bit; must be an even number ≥ 2
DEFAULT_DIV_INT, 163, integer divisor loaded at reset
DEFAULT_DIV_FRAC, 0, fractional divisor loaded at reset

Ports:
i_clock  in  1  system clock
i_reset  in  1  asynchronous, active-low reset
i_enable  in  1  count enable; low freezes all counters
i_sync  in  1  synchronous phase restart (pulse)
i_load  in  1  capture i_div_int/i_div_frac into the shadow registers (pulse)
i_div_int  in  NB_COUNT  new integer divisor
i_div_frac  in  NB_FRAC  new fractional divisor, in units of 1/2^NB_FRAC
o_tick  out  1  oversampling tick, one-cycle pulse
o_mid_tick  out  1  mid-bit strobe, one-cycle pulse
o_bit_tick  out  1  bit-boundary strobe, one-cycle pulse
o_pending  out  1  shadow divisor loaded but not yet applied
o_br_clock  out  1  square-wave bit clock (optional feature)

Behaviour:
- Reset (i_reset=0, asynchronous):
  - cnt=0, acc=0, sub=0, period=DEFAULT_DIV_INT.
  - Active and shadow divisors = DEFAULT_*.
  - All outputs 0.
- Divisor clamp: an effective div_int of 0 is treated as 1.
- Period counter:
  - On each enabled cycle, cnt increments.
  - On the edge where cnt==period-1, cnt wraps to 0 and o_tick is registered high for exactly one cycle.
  - First o_tick occurs at the period-th enabled rising edge after reset release.
- Fractional accumulator, updated on each wrap:
  - {carry,acc} = acc + div_frac.
  - Next period = div_int + carry.
  - Long-run mean period = div_int + div_frac/2^NB_FRAC.
  - The period never exceeds 2^NB_COUNT, so cnt fits in NB_COUNT bits.
- Sub counter (sub, 0..OVERSAMPLE-1), advanced on each wrap:
  - o_bit_tick asserts with the o_tick on which sub wraps OVERSAMPLE-1→0.
  - o_mid_tick asserts with the o_tick on which sub goes OVERSAMPLE/2-1→OVERSAMPLE/2.
- i_enable=0: cnt/acc/sub hold, no pulses; counting resumes seamlessly when enable returns.
- i_sync=1 (synchronous; has priority over counting):
  - cnt, acc and sub clear; period reloads from the active div_int.
  - No pulses that cycle; the next o_tick follows period cycles later.
- Load handshake:
  - i_load copies the inputs into the shadow registers and sets o_pending the following cycle.
  - Shadow→active transfer happens at the next wrap edge, on i_sync, or on any cycle with i_enable=0; o_pending clears on the same edge.
  - A new i_load while pending overwrites the shadow (last write wins).
  - i_load coincident with the apply edge: the old shadow applies, the new value is captured, and o_pending stays 1.
- Mid-operation reset: asynchronous return to reset values, including the divisor defaults.

Optional Feature:
BRG_SQUARE_OUT_EN
- Defined: o_br_clock is a registered 50%-duty square wave.
  - Toggles 0→1 on the o_bit_tick cycle and 1→0 on the o_mid_tick cycle.
  - Cleared by i_sync and by reset.
- Undefined: o_br_clock is tied to 0 and no toggle logic is synthesised.

Decomposition:
- Shared package uart_pkg:
  - NB_COUNT, NB_FRAC and OVERSAMPLE default constants.
  - DEFAULT_DIV_INT=163 and DEFAULT_DIV_FRAC=0.
  - Divisor localparams for the 100 MHz / 38400-baud configuration (int 162, frac 195).
  - Divisor struct typedef {div_int, div_frac}.
- One sub-module, brg_frac_accum: accumulator plus carry and next-period select.
- The counters and the load logic stay in the top module.

Test Plan:
1. Reset held 20 ns, then released with i_enable=1 and defaults → first o_tick at the 163rd edge, subsequent ticks every 163 cycles; first o_bit_tick at tick 16; o_mid_tick at tick 8.
2. Load div_int=4, div_frac=128, then i_sync → o_tick spacings 4,4,5,4,5,4,5 (31 cycles over 7 ticks).
3. i_enable dropped for 10 cycles mid-period at cnt=50 → no pulses while low; next o_tick arrives 113 enabled cycles later.
4. i_load of div 10 at cnt=20 → o_pending=1 until the wrap; the remainder of the current period stays 163; the following periods are 10; o_pending=0 after the wrap.
5. i_sync at sub=7 → sub=0; no o_mid_tick at the next tick; o_bit_tick arrives 16 ticks after the sync.
6. i_reset asserted mid-period with o_pending=1 → all outputs 0 immediately; divisor reverts to 163 and o_pending to 0; with BRG_SQUARE_OUT_EN, o_br_clock is high for 8 ticks and low for 8 ticks.
